regfile_write_buffer: RTL

//  Write-back stage sitting directly upstream of the 32x32 register file. Buffers

---
 rtl/simple_cpu_pkg.sv | 20 ++
 rtl/wb_fwd_match.sv | 43 ++++
 rtl/regfile_write_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/simple_cpu_pkg.sv
// ============================================================================
// Package : simple_cpu_pkg
// Shared register-file widths and the write-back entry layout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : simple_cpu_pkg

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// ============================================================================
// Module  : wb_fwd_match
// Youngest-match search over the buffered write entries for one lookup port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fwd_match
    import simple_cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  i_valid,
    input  logic [ADDR_W-1:0] i_rd   [DEPTH],
    input  logic [DATA_W-1:0] i_data [DEPTH],
    input  logic [PTR_W-1:0]  i_rd_ptr,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rd_ptr + PTR_W'(k);
            if (i_valid[w_idx] && (i_addr != '0) && (i_rd[w_idx] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule : wb_fwd_match

`default_nettype wire

// File: rtl/regfile_write_buffer.sv
// ============================================================================
// Module  : regfile_write_buffer
// In-order write-back FIFO in front of the register file, with forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_buffer
    import simple_cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [ADDR_W-1:0]        fwd_addr1,
    output logic                     fwd_hit1,
    output logic [DATA_W-1:0]        fwd_data1,
    input  logic [ADDR_W-1:0]        fwd_addr2,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth_cnt = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]      count_q,  count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]    valid_q,  valid_d;
    logic [ADDR_W-1:0]   rd_q   [DEPTH];
    logic [ADDR_W-1:0]   rd_d   [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];

    logic                w_not_empty;
    logic                w_deq;
    logic                w_space;
    logic                w_accept;
    logic                w_push;
    logic [ADDR_W-1:0]   w_in_reg;
    logic [DATA_W-1:0]   w_in_data;

    assign w_not_empty = (count_q != '0);
    assign w_deq       = w_not_empty & ~wb_hold;
    // A slot freed by this cycle's drain can be refilled in the same cycle.
    assign w_space     = (count_q < c_depth_cnt) | w_deq;

    assign mem_ready   = w_space;
    assign alu_ready   = w_space & ~mem_valid;

    assign w_accept    = (mem_valid & mem_ready) | (alu_valid & alu_ready);
    assign w_in_reg    = mem_valid ? mem_reg  : alu_reg;
    assign w_in_data   = mem_valid ? mem_data : alu_data;
    // Writes to r0 complete the handshake but are dropped.
    assign w_push      = w_accept & (w_in_reg != '0);

    assign RegWrite    = w_deq;
    assign WriteReg    = w_not_empty ? rd_q[rd_ptr_q]   : '0;
    assign WriteData   = w_not_empty ? data_q[rd_ptr_q] : '0;
    assign pending     = count_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        rd_d     = rd_q;
        data_d   = data_q;

        if (w_deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        // Set after clear: when full with enq+deq both pointers address one slot.
        if (w_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = w_in_reg;
            data_d[wr_ptr_q]  = w_in_data;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_deq);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_fwd1 (
        .i_valid  (valid_q),
        .i_rd     (rd_q),
        .i_data   (data_q),
        .i_rd_ptr (rd_ptr_q),
        .i_addr   (fwd_addr1),
        .o_hit    (fwd_hit1),
        .o_data   (fwd_data1)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_fwd2 (
        .i_valid  (valid_q),
        .i_rd     (rd_q),
        .i_data   (data_q),
        .i_rd_ptr (rd_ptr_q),
        .i_addr   (fwd_addr2),
        .o_hit    (fwd_hit2),
        .o_data   (fwd_data2)
    );

endmodule : regfile_write_buffer

`default_nettype wire
